rc4_encrypt_core: RTL and testbench

- RC4 encryptor: the encode-side counterpart of the brute-force decrypt cores.
- Given a 24-bit key and a plaintext message in a sync ROM/RAM, it runs the S-box init, the key schedule (KSA) and keystream generation (PRGA), then writes ciphertext into a 32x8 RAM.
- Its output produces the encrypted-message images that the decrypt cores load as their encoded ROM, and it serves as the golden stimulus generator for the key-search tests.
- It drives one external 256x8 single-port S memory with a 1-cycle read latency.

---
 rtl/rc4_encrypt_core.sv | 223 ++++++++++++++++++++++
 tb/tb_rc4_encrypt_core.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_encrypt_core.sv
// RC4 encryptor: S-box init, key schedule (KSA), keystream generation (PRGA),
// then writes plaintext XOR keystream into a ciphertext RAM.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   start             - request, sampled only in IDLE; secret_key latched then
//   busy / done       - busy from the cycle after accept through DONE; done 1-cycle pulse
//   s_address/s_data/s_wren/s_q - external 256x8 S memory, 1-cycle read latency
//   pt_address/pt_q   - plaintext memory, 1-cycle read latency
//   ct_address/ct_data/ct_wren  - ciphertext RAM write port
module rc4_encrypt_core #(
    parameter int unsigned KEY_BYTES = 3,
    parameter int unsigned MSG_LEN   = 32,
    parameter int unsigned MSG_AW    = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             s_address,
    output logic [7:0]             s_data,
    output logic                   s_wren,
    input  logic [7:0]             s_q,
    output logic [MSG_AW-1:0]      pt_address,
    input  logic [7:0]             pt_q,
    output logic [MSG_AW-1:0]      ct_address,
    output logic [7:0]             ct_data,
    output logic                   ct_wren
);

    localparam int unsigned KEY_W = 8 * KEY_BYTES;

    typedef enum logic [4:0] {
        S_IDLE, S_INIT,
        S_K_RD_I, S_K_LT_I, S_K_RD_J, S_K_LT_J, S_K_WR_I, S_K_WR_J,
        S_P_RD_I, S_P_LT_I, S_P_RD_J, S_P_LT_J, S_P_WR_I, S_P_WR_J,
        S_P_RD_F, S_P_WR_CT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [MSG_AW-1:0]   k_q, k_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [7:0]          s_address_d, s_data_d;
    logic                s_wren_d, ct_wren_d, busy_d, done_d;
    logic [MSG_AW-1:0]   pt_address_d, ct_address_d;
    logic [7:0]          key_idx, key_byte;

    // Keystream byte and plaintext both arrive in P_WR_CT, so the XOR cannot be
    // registered without moving the write; gate it so it reads 0 when idle/reset.
    assign ct_data = ct_wren ? (s_q ^ pt_q) : 8'h00;

    // Key byte for the current i; byte 0 is the MSB of the key
    always_comb begin
        key_idx  = i_q % 8'(KEY_BYTES);
        key_byte = 8'(key_q >> {8'(KEY_BYTES - 1) - key_idx, 3'b000});
    end

    // Next-state and next-output logic; outputs describe the state being entered
    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        j_d          = j_q;
        k_d          = k_q;
        key_d        = key_q;
        si_d         = si_q;
        sj_d         = sj_q;
        s_address_d  = s_address;
        s_data_d     = s_data;
        s_wren_d     = 1'b0;
        pt_address_d = pt_address;
        ct_address_d = ct_address;
        ct_wren_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d       = secret_key;
                    i_d         = 8'h00;
                    j_d         = 8'h00;
                    k_d         = '0;
                    state_d     = S_INIT;
                    s_address_d = 8'h00;
                    s_data_d    = 8'h00;
                    s_wren_d    = 1'b1;
                end
            end
            S_INIT: begin
                if (i_q == 8'hFF) begin
                    i_d         = 8'h00;
                    j_d         = 8'h00;
                    state_d     = S_K_RD_I;
                    s_address_d = 8'h00;
                end else begin
                    i_d         = i_q + 8'd1;
                    s_address_d = i_q + 8'd1;
                    s_data_d    = i_q + 8'd1;
                    s_wren_d    = 1'b1;
                end
            end
            S_K_RD_I: state_d = S_K_LT_I;
            S_K_LT_I: begin
                si_d        = s_q;
                j_d         = j_q + s_q + key_byte;
                s_address_d = j_q + s_q + key_byte;
                state_d     = S_K_RD_J;
            end
            S_K_RD_J: state_d = S_K_LT_J;
            S_K_LT_J: begin
                sj_d        = s_q;
                s_address_d = i_q;
                s_data_d    = s_q;
                s_wren_d    = 1'b1;
                state_d     = S_K_WR_I;
            end
            S_K_WR_I: begin
                s_address_d = j_q;
                s_data_d    = si_q;
                s_wren_d    = 1'b1;
                state_d     = S_K_WR_J;
            end
            S_K_WR_J: begin
                if (i_q == 8'hFF) begin
                    // PRGA starts from i=0 and pre-increments on entry to P_RD_I
                    i_d         = 8'd1;
                    j_d         = 8'h00;
                    s_address_d = 8'd1;
                    state_d     = S_P_RD_I;
                end else begin
                    i_d         = i_q + 8'd1;
                    s_address_d = i_q + 8'd1;
                    state_d     = S_K_RD_I;
                end
            end
            S_P_RD_I: state_d = S_P_LT_I;
            S_P_LT_I: begin
                si_d        = s_q;
                j_d         = j_q + s_q;
                s_address_d = j_q + s_q;
                state_d     = S_P_RD_J;
            end
            S_P_RD_J: state_d = S_P_LT_J;
            S_P_LT_J: begin
                sj_d        = s_q;
                s_address_d = i_q;
                s_data_d    = s_q;
                s_wren_d    = 1'b1;
                state_d     = S_P_WR_I;
            end
            S_P_WR_I: begin
                s_address_d = j_q;
                s_data_d    = si_q;
                s_wren_d    = 1'b1;
                state_d     = S_P_WR_J;
            end
            S_P_WR_J: begin
                s_address_d  = si_q + sj_q;
                pt_address_d = k_q;
                state_d      = S_P_RD_F;
            end
            S_P_RD_F: begin
                ct_address_d = k_q;
                ct_wren_d    = 1'b1;
                state_d      = S_P_WR_CT;
            end
            S_P_WR_CT: begin
                k_d = k_q + MSG_AW'(1);
                if (k_q == MSG_AW'(MSG_LEN - 1)) begin
                    state_d = S_DONE;
                end else begin
                    i_d         = i_q + 8'd1;
                    s_address_d = i_q + 8'd1;
                    state_d     = S_P_RD_I;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            i_q        <= 8'h00;
            j_q        <= 8'h00;
            k_q        <= '0;
            key_q      <= '0;
            si_q       <= 8'h00;
            sj_q       <= 8'h00;
            s_address  <= 8'h00;
            s_data     <= 8'h00;
            s_wren     <= 1'b0;
            pt_address <= '0;
            ct_address <= '0;
            ct_wren    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            key_q      <= key_d;
            si_q       <= si_d;
            sj_q       <= sj_d;
            s_address  <= s_address_d;
            s_data     <= s_data_d;
            s_wren     <= s_wren_d;
            pt_address <= pt_address_d;
            ct_address <= ct_address_d;
            ct_wren    <= ct_wren_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_rc4_encrypt_core.sv
// Self-checking bench for rc4_encrypt_core: behavioural RC4 model, memory
// models for S / plaintext / ciphertext, and a cycle-pattern monitor.
module tb_rc4_encrypt_core;

    localparam int TOTAL_LAT = 1 + 256 + 1536 + 8 * 32;

    logic        clk, reset, start;
    logic [23:0] secret_key;
    logic        busy, done, s_wren, ct_wren;
    logic [7:0]  s_address, s_data, s_q, pt_q, ct_data;
    logic [4:0]  pt_address, ct_address;

    logic [7:0]  s_mem  [256];
    logic [7:0]  pt_mem [32];
    logic [7:0]  ct_mem [32];
    logic [7:0]  exp_ct [32];
    logic [7:0]  orig   [32];

    int checks, failures;
    int mon_checks, mon_fail, mon_cyc;
    bit mon_en;

    rc4_encrypt_core #(.KEY_BYTES(3), .MSG_LEN(32), .MSG_AW(5)) dut (
        .clk(clk), .reset(reset), .start(start), .secret_key(secret_key),
        .busy(busy), .done(done),
        .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
        .pt_address(pt_address), .pt_q(pt_q),
        .ct_address(ct_address), .ct_data(ct_data), .ct_wren(ct_wren)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s_wren) s_mem[s_address] <= s_data;
        s_q  <= s_mem[s_address];
        pt_q <= pt_mem[pt_address];
        if (ct_wren) ct_mem[ct_address] <= ct_data;
    end

    // Expected write/done timeline, counted from the first busy cycle
    always @(negedge clk) begin
        if (mon_en) begin
            bit es, ec, ed;
            if (busy === 1'b1) begin
                mon_cyc = mon_cyc + 1;
                es = 0; ec = 0; ed = 0;
                if (mon_cyc <= 256) es = 1;
                else if (mon_cyc <= 1792) es = ((mon_cyc - 257) % 6) >= 4;
                else if (mon_cyc <= 2048) begin
                    es = ((mon_cyc - 1793) % 8) == 4 || ((mon_cyc - 1793) % 8) == 5;
                    ec = ((mon_cyc - 1793) % 8) == 7;
                end else ed = (mon_cyc == TOTAL_LAT);
            end else begin
                mon_cyc = 0; es = 0; ec = 0; ed = 0;
            end
            mon_checks++;
            if (s_wren !== es || ct_wren !== ec || done !== ed) begin
                mon_fail++;
                if (mon_fail <= 5)
                    $display("FAIL wren_pattern cyc=%0d got s_wren=%b ct_wren=%b done=%b expected %b %b %b",
                             mon_cyc, s_wren, ct_wren, done, es, ec, ed);
            end
        end
    end

    // Plain software RC4 over pt_mem; also reports i==j occurrences
    task automatic model_run(input logic [23:0] key, output bit ksa_eq, output bit prga_eq);
        int s[256];
        int i, j, t, kb;
        ksa_eq = 0; prga_eq = 0;
        for (int n = 0; n < 256; n++) s[n] = n;
        j = 0;
        for (int n = 0; n < 256; n++) begin
            kb = int'((key >> (8 * (2 - (n % 3)))) & 24'hFF);
            j = (j + s[n] + kb) & 255;
            if (n == j) ksa_eq = 1;
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        i = 0; j = 0;
        for (int k = 0; k < 32; k++) begin
            i = (i + 1) & 255;
            j = (j + s[i]) & 255;
            if (i == j) prga_eq = 1;
            t = s[i]; s[i] = s[j]; s[j] = t;
            exp_ct[k] = pt_mem[k] ^ 8'(s[(s[i] + s[j]) & 255]);
        end
    endtask

    task automatic do_run(input logic [23:0] key, input bit poke, output int lat, output int extra_done);
        secret_key = key;
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        lat = 1;
        while (done !== 1'b1 && lat < 3000) begin
            @(negedge clk);
            lat++;
            start = poke && (lat == 100 || lat == 1000 || lat == 1900);
        end
        start = 0;
        extra_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) extra_done++;
        end
    endtask

    task automatic test_reset;
        reset = 1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b expected 0", done); end
        checks++; if (s_wren !== 1'b0 || ct_wren !== 1'b0) begin failures++; $display("FAIL reset_wren got %b%b expected 00", s_wren, ct_wren); end
        checks++; if (s_address !== 8'h00 || s_data !== 8'h00) begin failures++; $display("FAIL reset_s_bus got %h/%h expected 00/00", s_address, s_data); end
        checks++; if (pt_address !== 5'd0 || ct_address !== 5'd0 || ct_data !== 8'h00) begin failures++; $display("FAIL reset_msg_bus got %h/%h/%h expected 0", pt_address, ct_address, ct_data); end
        reset = 0;
        mon_en = 1;
        @(negedge clk);
    endtask

    task automatic test_known_vector;
        logic [7:0] ptxt [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        logic [7:0] kv   [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        int lat, extra;
        bit a, b;
        for (int n = 0; n < 32; n++) pt_mem[n] = (n < 9) ? ptxt[n] : 8'h00;
        model_run(24'h4B6579, a, b);
        do_run(24'h4B6579, 0, lat, extra);
        checks++; if (lat !== TOTAL_LAT) begin failures++; $display("FAIL kv_latency got %0d expected %0d", lat, TOTAL_LAT); end
        for (int n = 0; n < 9; n++) begin
            checks++;
            if (ct_mem[n] !== kv[n]) begin failures++; $display("FAIL kv_ct[%0d] got %h expected %h", n, ct_mem[n], kv[n]); end
        end
        for (int n = 9; n < 32; n++) begin
            checks++;
            if (ct_mem[n] !== exp_ct[n]) begin failures++; $display("FAIL kv_tail[%0d] got %h expected %h", n, ct_mem[n], exp_ct[n]); end
        end
    endtask

    task automatic test_keystream;
        int lat, extra;
        bit a, b;
        for (int n = 0; n < 32; n++) pt_mem[n] = 8'h00;
        model_run(24'h4B6579, a, b);
        do_run(24'h4B6579, 0, lat, extra);
        checks++; if (ct_mem[0] !== 8'hEB) begin failures++; $display("FAIL ks_byte0 got %h expected eb", ct_mem[0]); end
        checks++; if (ct_mem[1] !== 8'h9F) begin failures++; $display("FAIL ks_byte1 got %h expected 9f", ct_mem[1]); end
        for (int n = 0; n < 32; n++) begin
            checks++;
            if (ct_mem[n] !== exp_ct[n]) begin failures++; $display("FAIL ks[%0d] got %h expected %h", n, ct_mem[n], exp_ct[n]); end
        end
    endtask

    task automatic test_round_trip;
        int lat, extra;
        bit a, b;
        for (int n = 0; n < 32; n++) begin pt_mem[n] = 8'($urandom); orig[n] = pt_mem[n]; end
        model_run(24'h000123, a, b);
        do_run(24'h000123, 0, lat, extra);
        for (int n = 0; n < 32; n++) begin
            checks++;
            if (ct_mem[n] !== exp_ct[n]) begin failures++; $display("FAIL rt_enc[%0d] got %h expected %h", n, ct_mem[n], exp_ct[n]); end
        end
        for (int n = 0; n < 32; n++) pt_mem[n] = ct_mem[n];
        do_run(24'h000123, 0, lat, extra);
        for (int n = 0; n < 32; n++) begin
            checks++;
            if (ct_mem[n] !== orig[n]) begin failures++; $display("FAIL rt_dec[%0d] got %h expected %h", n, ct_mem[n], orig[n]); end
        end
    endtask

    task automatic test_start_ignored;
        int lat, extra;
        bit a, b;
        logic [23:0] key;
        key = 24'($urandom);
        for (int n = 0; n < 32; n++) pt_mem[n] = 8'($urandom);
        model_run(key, a, b);
        do_run(key, 1, lat, extra);
        checks++; if (lat !== TOTAL_LAT) begin failures++; $display("FAIL poke_latency got %0d expected %0d", lat, TOTAL_LAT); end
        checks++; if (extra !== 0) begin failures++; $display("FAIL poke_extra_done got %0d expected 0", extra); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL poke_restart busy got %b expected 0", busy); end
        for (int n = 0; n < 32; n++) begin
            checks++;
            if (ct_mem[n] !== exp_ct[n]) begin failures++; $display("FAIL poke_ct[%0d] got %h expected %h", n, ct_mem[n], exp_ct[n]); end
        end
    endtask

    task automatic test_mid_reset;
        logic [7:0] kv [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        logic [7:0] ptxt [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        int lat, extra;
        secret_key = 24'h4B6579;
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        lat = 1;
        while (lat < 1000) begin @(negedge clk); lat++; end
        reset = 1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mreset_busy got %b expected 0", busy); end
        checks++; if (s_wren !== 1'b0 || ct_wren !== 1'b0) begin failures++; $display("FAIL mreset_wren got %b%b expected 00", s_wren, ct_wren); end
        checks++; if (s_address !== 8'h00 || done !== 1'b0) begin failures++; $display("FAIL mreset_outs got addr=%h done=%b expected 00/0", s_address, done); end
        reset = 0;
        for (int n = 0; n < 32; n++) pt_mem[n] = (n < 9) ? ptxt[n] : 8'h00;
        do_run(24'h4B6579, 0, lat, extra);
        checks++; if (lat !== TOTAL_LAT) begin failures++; $display("FAIL mreset_latency got %0d expected %0d", lat, TOTAL_LAT); end
        for (int n = 0; n < 9; n++) begin
            checks++;
            if (ct_mem[n] !== kv[n]) begin failures++; $display("FAIL mreset_ct[%0d] got %h expected %h", n, ct_mem[n], kv[n]); end
        end
    endtask

    task automatic test_collision;
        int lat, extra;
        bit a, b, found;
        logic [23:0] key;
        found = 0;
        key = 24'h0;
        for (int n = 0; n < 32; n++) pt_mem[n] = 8'($urandom);
        for (int t = 0; t < 4000 && !found; t++) begin
            key = 24'($urandom);
            model_run(key, a, b);
            found = a && b;
        end
        checks++;
        if (!found) begin failures++; $display("FAIL collision_search got none expected a key"); end
        else begin
            model_run(key, a, b);
            do_run(key, 0, lat, extra);
            for (int n = 0; n < 32; n++) begin
                checks++;
                if (ct_mem[n] !== exp_ct[n]) begin failures++; $display("FAIL coll_ct[%0d] key=%h got %h expected %h", n, key, ct_mem[n], exp_ct[n]); end
            end
        end
    endtask

    task automatic test_random_keys;
        int lat, extra;
        bit a, b;
        logic [23:0] key;
        repeat (2) begin
            key = 24'($urandom);
            for (int n = 0; n < 32; n++) pt_mem[n] = 8'($urandom);
            model_run(key, a, b);
            do_run(key, 0, lat, extra);
            for (int n = 0; n < 32; n++) begin
                checks++;
                if (ct_mem[n] !== exp_ct[n]) begin failures++; $display("FAIL rand_ct[%0d] key=%h got %h expected %h", n, key, ct_mem[n], exp_ct[n]); end
            end
        end
    endtask

    task automatic test_monitor_summary;
        checks++; if (mon_fail !== 0) begin failures++; $display("FAIL timeline got %0d bad cycles expected 0", mon_fail); end
        checks++; if (mon_checks < TOTAL_LAT) begin failures++; $display("FAIL timeline_coverage got %0d samples expected >= %0d", mon_checks, TOTAL_LAT); end
    endtask

    initial begin
        clk = 0; reset = 1; start = 0; secret_key = '0;
        checks = 0; failures = 0;
        mon_checks = 0; mon_fail = 0; mon_cyc = 0; mon_en = 0;
        test_reset();
        test_known_vector();
        test_keystream();
        test_round_trip();
        test_start_ignored();
        test_mid_reset();
        test_collision();
        test_random_keys();
        test_monitor_summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
